// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory responder.
//   mem_size_e   : access width encoding carried on req_size.
//   resp_state_e : responder FSM states.
//   WORD_W       : width of one memory word and of the data buses.
package riscv_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_X = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

endpackage

// File: rtl/data_mem_lane_align.sv
// Combinational lane steering for a little-endian, word-organised memory.
//   lane        : byte offset within the word (addr[1:0]).
//   size        : access width.
//   is_unsigned : zero-extend loads when set, sign-extend otherwise.
//   wdata       : right-aligned store data.
//   rword       : raw word read from the array.
//   be          : per-byte write enables for the store.
//   wdata_lane  : store data replicated onto every lane it could occupy.
//   rdata_ext   : load data shifted down and extended.
//   misalign    : half on an odd address, or word off a word boundary.
module data_mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]        lane,
  input  mem_size_e         size,
  input  logic              is_unsigned,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] rword,
  output logic [3:0]        be,
  output logic [WORD_W-1:0] wdata_lane,
  output logic [WORD_W-1:0] rdata_ext,
  output logic              misalign
);

  logic [WORD_W-1:0] shifted;

  // Replicating the data onto all lanes lets the byte enables alone pick
  // where it lands, so no store-side shifter is needed.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign be[gi] = ((size == SIZE_B) && (lane == LANE)) ||
                    ((size == SIZE_H) && (lane[1] == LANE[1])) ||
                    (size == SIZE_W);
    assign wdata_lane[gi*8 +: 8] = (size == SIZE_B) ? wdata[7:0] :
                                   (size == SIZE_H) ? wdata[(gi%2)*8 +: 8] :
                                                      wdata[gi*8 +: 8];
  end

  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    rdata_ext = '0;
    case (size)
      SIZE_B:  rdata_ext = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_H:  rdata_ext = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      SIZE_W:  rdata_ext = rword;
      default: rdata_ext = '0;
    endcase
  end

  assign misalign = ((size == SIZE_H) && lane[0]) ||
                    ((size == SIZE_W) && (lane != 2'b00));

endmodule

// File: rtl/data_mem_responder.sv
// Memory end of the MEM-stage load/store interface. Accepts one request
// at a time, waits WAIT_STATES cycles, then returns a one-cycle response.
//   clk, reset    : clock and asynchronous active-high reset.
//   req_*         : request, held stable by the requester until rsp_valid.
//   busy          : stall to the pipeline while an access is outstanding.
//   rsp_valid     : one-cycle completion strobe.
//   rsp_rdata     : extended load data (0 for stores and errors).
//   rsp_err       : error flag, qualified by rsp_valid.
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              busy,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  resp_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  mem_size_e         size_q;
  logic              uns_q, rd_q, wr_q;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  logic              in_idle, req_any;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  mem_size_e         acc_size;
  logic              acc_uns, acc_rd, acc_wr, acc_err;
  logic [AW-1:0]     word_idx;
  logic              out_of_range, commit, mem_we;
  logic [3:0]        be;
  logic [WORD_W-1:0] wdata_lane, rdata_ext;
  logic              misalign;

  assign in_idle = (state_q == IDLE);
  assign req_any = req_read | req_write;

  // With zero wait states the commit edge is the acceptance edge, so the
  // access must be taken straight from the ports rather than the latches.
  assign acc_addr  = in_idle ? req_addr               : addr_q;
  assign acc_wdata = in_idle ? req_wdata              : wdata_q;
  assign acc_size  = in_idle ? mem_size_e'(req_size)  : size_q;
  assign acc_uns   = in_idle ? req_unsigned           : uns_q;
  assign acc_rd    = in_idle ? req_read               : rd_q;
  assign acc_wr    = in_idle ? req_write              : wr_q;

  assign word_idx     = acc_addr[AW+1:2];
  assign out_of_range = (acc_addr[31:2] >= DEPTH_LIM);

  data_mem_lane_align u_align (
    .lane        (acc_addr[1:0]),
    .size        (acc_size),
    .is_unsigned (acc_uns),
    .wdata       (acc_wdata),
    .rword       (mem_q[word_idx]),
    .be          (be),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  assign acc_err = misalign | (acc_size == SIZE_X) | out_of_range | (acc_rd & acc_wr);

  assign commit = (in_idle && req_any && (WAIT_STATES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd0));
  // A store still in flight when reset arrives must not reach the array.
  assign mem_we = commit && acc_wr && !acc_err && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    busy = req_any;
        WAIT:    busy = 1'b1;
        default: busy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_idle && req_any) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= mem_size_e'(req_size);
        uns_q   <= req_unsigned;
        rd_q    <= req_read;
        wr_q    <= req_write;
      end
      if (commit) begin
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (acc_err || !acc_rd) ? '0 : rdata_ext;
      end
    end
  end

  // Array contents survive reset; only the byte lanes selected are written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import riscv_mem_pkg::*;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sel0;
  logic        req_read, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        rd2, wr2, rd0, wr0;
  logic        busy2, valid2, err2, busy0, valid0, err0;
  logic [31:0] rdata2, rdata0;
  logic        busy_s, valid_s, err_s;
  logic [31:0] rdata_s;

  // sel0 routes the request to the zero-wait-state instance.
  assign rd2 = req_read  & ~sel0;
  assign wr2 = req_write & ~sel0;
  assign rd0 = req_read  &  sel0;
  assign wr0 = req_write &  sel0;
  assign busy_s  = sel0 ? busy0  : busy2;
  assign valid_s = sel0 ? valid0 : valid2;
  assign rdata_s = sel0 ? rdata0 : rdata2;
  assign err_s   = sel0 ? err0   : err2;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .req_read(rd2), .req_write(wr2),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .busy(busy2), .rsp_valid(valid2),
    .rsp_rdata(rdata2), .rsp_err(err2));

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req_read(rd0), .req_write(wr0),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .busy(busy0), .rsp_valid(valid0),
    .rsp_rdata(rdata0), .rsp_err(err0));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size,
                              input logic uns, input logic [31:0] er, input logic ee);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.size = size;
    v.uns = uns; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // Drive one request, hold it until rsp_valid, then confirm the strobe
  // lasted a single cycle. Samples are taken 2 time units after posedge.
  task automatic access(input vec_t v, output logic [31:0] rdata, output logic err,
                        output int busy_cnt, output int lat);
    bit done = 1'b0;
    @(negedge clk);
    req_read = v.rd; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns;
    #1;
    busy_cnt = 0; lat = -1; rdata = '0; err = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      if (busy_s) busy_cnt++;
      if (valid_s) begin
        lat = k; rdata = rdata_s; err = err_s; done = 1'b1;
      end else begin
        @(posedge clk); #2;
      end
    end
    req_read = 1'b0; req_write = 1'b0;
    @(posedge clk); #2;
    check("strobe_one_cycle", {31'd0, valid_s}, 32'd0);
  endtask

  task automatic apply(input vec_t v, input int ws, input string tag);
    logic [31:0] rdata;
    logic        err;
    int          bc, lat;
    access(v, rdata, err, bc, lat);
    check({tag, "_rdata"},   rdata, v.exp_rdata);
    check({tag, "_err"},     {31'd0, err}, {31'd0, v.exp_err});
    check({tag, "_latency"}, 32'(lat), 32'(ws + 1));
    check({tag, "_busy"},    32'(bc),  32'(ws + 1));
    $display("%s rd=%0d wr=%0d addr=0x%08h wdata=0x%08h size=%0d uns=%0d -> rdata=0x%08h err=%0d lat=%0d busy=%0d",
             tag, v.rd, v.wr, v.addr, v.wdata, v.size, v.uns, rdata, err, lat, bc);
  endtask

  vec_t vecs2[25];
  vec_t vecs0[4];

  initial begin
    vecs2[0]  = mk(0, 1, 32'h10,   32'hDEADBEEF, 2, 0, 32'h0,        0);
    vecs2[1]  = mk(1, 0, 32'h10,   32'h0,        2, 0, 32'hDEADBEEF, 0);
    vecs2[2]  = mk(1, 0, 32'h13,   32'h0,        0, 0, 32'hFFFFFFDE, 0);
    vecs2[3]  = mk(1, 0, 32'h13,   32'h0,        0, 1, 32'h000000DE, 0);
    vecs2[4]  = mk(1, 0, 32'h12,   32'h0,        1, 0, 32'hFFFFDEAD, 0);
    vecs2[5]  = mk(1, 0, 32'h10,   32'h0,        1, 1, 32'h0000BEEF, 0);
    vecs2[6]  = mk(0, 1, 32'h11,   32'hFFFFFF55, 0, 0, 32'h0,        0);
    vecs2[7]  = mk(1, 0, 32'h10,   32'h0,        2, 0, 32'hDEAD55EF, 0);
    vecs2[8]  = mk(0, 1, 32'h14,   32'hA5A5A5A5, 2, 0, 32'h0,        0);
    vecs2[9]  = mk(1, 0, 32'h12,   32'h0,        2, 0, 32'h0,        1);
    vecs2[10] = mk(1, 0, 32'h14,   32'h0,        2, 0, 32'hA5A5A5A5, 0);
    vecs2[11] = mk(0, 1, 32'h16,   32'h12345678, 2, 0, 32'h0,        1);
    vecs2[12] = mk(1, 0, 32'h14,   32'h0,        2, 0, 32'hA5A5A5A5, 0);
    vecs2[13] = mk(1, 0, 32'h1000, 32'h0,        2, 0, 32'h0,        1);
    vecs2[14] = mk(1, 0, 32'h14,   32'h0,        2, 0, 32'hA5A5A5A5, 0);
    vecs2[15] = mk(1, 1, 32'h14,   32'h0,        2, 0, 32'h0,        1);
    vecs2[16] = mk(1, 0, 32'h14,   32'h0,        2, 0, 32'hA5A5A5A5, 0);
    vecs2[17] = mk(1, 0, 32'h14,   32'h0,        3, 0, 32'h0,        1);
    vecs2[18] = mk(1, 0, 32'h13,   32'h0,        1, 0, 32'h0,        1);
    vecs2[19] = mk(0, 1, 32'h16,   32'h00008001, 1, 0, 32'h0,        0);
    vecs2[20] = mk(1, 0, 32'h16,   32'h0,        1, 0, 32'hFFFF8001, 0);
    vecs2[21] = mk(1, 0, 32'h14,   32'h0,        2, 0, 32'h8001A5A5, 0);
    vecs2[22] = mk(0, 1, 32'hFFC,  32'h600DCAFE, 2, 0, 32'h0,        0);
    vecs2[23] = mk(1, 0, 32'hFFC,  32'h0,        2, 0, 32'h600DCAFE, 0);
    vecs2[24] = mk(1, 0, 32'h11,   32'h0,        0, 0, 32'h00000055, 0);

    vecs0[0] = mk(0, 1, 32'h40, 32'h0BADF00D, 2, 0, 32'h0,        0);
    vecs0[1] = mk(1, 0, 32'h40, 32'h0,        2, 0, 32'h0BADF00D, 0);
    vecs0[2] = mk(1, 0, 32'h41, 32'h0,        0, 0, 32'hFFFFFFF0, 0);
    vecs0[3] = mk(1, 0, 32'h41, 32'h0,        2, 0, 32'h0,        1);

    // Reset state, with a request held to show busy stays low under reset.
    reset = 1'b1; sel0 = 1'b0;
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = '0;
    req_size = 2'd2; req_unsigned = 1'b0;
    #12;
    check("reset_busy2",  {31'd0, busy2},  32'd0);
    check("reset_valid2", {31'd0, valid2}, 32'd0);
    check("reset_rdata2", rdata2,          32'd0);
    check("reset_err2",   {31'd0, err2},   32'd0);
    check("reset_valid0", {31'd0, valid0}, 32'd0);
    req_read = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #2;
    $display("reset: busy=%0d valid=%0d rdata=0x%08h err=%0d", busy2, valid2, rdata2, err2);

    for (int i = 0; i < 25; i++) apply(vecs2[i], 2, $sformatf("ws2_v%0d", i));

    // Store interrupted by reset while waiting must not land.
    apply(mk(0, 1, 32'h20, 32'h11223344, 2, 0, 32'h0, 0), 2, "ws2_pre_store");
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_size = 2'd2;
    #1;
    check("rst_wait_busy_accept", {31'd0, busy_s}, 32'd1);
    @(posedge clk); #2;
    check("rst_wait_busy_wait", {31'd0, busy_s}, 32'd1);
    @(posedge clk); #2;
    reset = 1'b1; req_write = 1'b0;
    #1;
    check("rst_wait_busy",  {31'd0, busy_s},  32'd0);
    check("rst_wait_valid", {31'd0, valid_s}, 32'd0);
    @(posedge clk); #2;
    check("rst_wait_valid_hold", {31'd0, valid_s}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #2;
    check("rst_wait_valid_after", {31'd0, valid_s}, 32'd0);
    $display("reset-in-wait: busy=%0d valid=%0d", busy_s, valid_s);
    apply(mk(1, 0, 32'h20, 32'h0, 2, 0, 32'h11223344, 0), 2, "ws2_post_reset_load");

    sel0 = 1'b1;
    for (int i = 0; i < 4; i++) apply(vecs0[i], 0, $sformatf("ws0_v%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (memory) end of the pipeline's MEM-stage load/store interface.
- Accepts one read or write request at a time, waits a configurable number of cycles, then returns load data or an error with a single-cycle response strobe.
- Drives `busy` so the pipeline's hazard logic can freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Little-endian and word-organised; supports byte, half and word accesses with sign or zero extension.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; must be a power of two.
- WAIT_STATES, 2, extra cycles between acceptance and response; range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_read  in  1  load request; held stable by requester until rsp_valid.
- req_write  in  1  store request; held stable until rsp_valid.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- req_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
- busy  out  1  stall request to the pipeline.
- rsp_valid  out  1  one-cycle strobe marking response completion.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  error flag, qualified by rsp_valid.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (async, any state): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - busy=0 while reset is high.
  - Array contents are not cleared; an in-flight store is dropped and does not write.
- IDLE:
  - If (req_read|req_write), latch addr/wdata/size/unsigned/op and go to WAIT (WAIT_STATES>0, counter=WAIT_STATES-1) or RESP (WAIT_STATES=0).
  - busy = req_read|req_write, combinational, in this cycle.
- WAIT: busy=1. Decrement the counter each cycle; at 0 go to RESP.
- Array commit happens on the edge entering RESP. The store updates the addressed byte lanes; the load reads the word into rsp_rdata.
- RESP:
  - rsp_valid=1 and busy=0 for exactly one cycle; unconditional return to IDLE.
  - Request inputs are ignored in RESP (the requester is advancing), so back-to-back accesses have one idle cycle between them.
- Latency: acceptance cycle to rsp_valid cycle = WAIT_STATES+1 cycles. busy is high for WAIT_STATES+1 cycles.
- Lanes: lane = addr[1:0].
  - Byte: any lane.
  - Half: lane 0 or 2; half data is [15:0] at lane 0 and [31:16] at lane 2.
  - Word: lane 0.
  - Loads are shifted down and then extended per req_unsigned.
- Errors (rsp_err=1, no array write, rsp_rdata=0):
  - Misaligned half (addr[0]=1) or misaligned word (addr[1:0]!=0).
  - req_size=3.
  - addr[31:2] >= DEPTH_WORDS.
  - req_read and req_write both high.
- Errors still take the full WAIT_STATES+1 latency.
- rsp_rdata and rsp_err hold their last values outside RESP; consumers must qualify them with rsp_valid.

Decomposition:
- Package riscv_mem_pkg holds:
  - mem_size_e enum (SIZE_B, SIZE_H, SIZE_W, SIZE_X).
  - resp_state_e enum (IDLE, WAIT, RESP).
  - WORD_W=32 constant.
- One combinational sub-module, data_mem_lane_align, handles:
  - store byte-enable and write-data lane replication;
  - load shift plus sign/zero extension;
  - misalignment detect.
- The FSM, counter and array stay in the top module.

Test Plan:
- WAIT_STATES=2, store word 0xDEADBEEF at 0x10 -> busy high 3 cycles, rsp_valid in cycle 3, rsp_err=0. A following word load at 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte load at 0x13: signed -> 0xFFFFFFDE, unsigned -> 0x000000DE. Half load at 0x12 signed -> 0xFFFFDEAD. Half load at 0x10 unsigned -> 0x0000BEEF.
- Byte store 0x55 to 0x11, then word load at 0x10 -> 0xDEAD55EF. WAIT_STATES=0 variant -> busy 1 cycle, rsp_valid next cycle.
- Errors, each -> rsp_err=1, rsp_rdata=0, and a word load at 0x14 is unchanged afterwards:
  - word load at 0x12;
  - word store 0x12345678 at 0x16;
  - word load at 0x1000 (DEPTH_WORDS=1024);
  - read+write together.
- Reset pulse during WAIT of a word store 0xCAFEF00D at 0x20 -> immediately IDLE, busy=0, no rsp_valid. A word load at 0x20 returns the previous contents.
